// File: rtl/bk_loader_pkg.sv
// Shared types for the BK .bin loader: FSM states, write-queue entry and address defaults.
// Header parsing is compiled in only when BK_BIN_HEADER_EN is defined.
package bk_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_ADDR,
    HDR_LEN,
    DATA,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
  } fifo_entry_t;

  localparam logic [24:0] DL_BASE_DEFAULT  = 25'h00A0000;
  localparam logic [24:0] RAM_BASE_DEFAULT = 25'h0000000;

  // Word position of a download address inside the file.
  function automatic logic [23:0] word_index(input logic [24:0] addr, input logic [24:0] base);
    logic [24:0] off;
    off = addr - base;
    return 24'(off >> 1);
  endfunction

endpackage

// File: rtl/bk_wr_fifo.sv
// Small synchronous write queue; head entry is visible combinationally while not empty.
module bk_wr_fifo
  import bk_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  fifo_entry_t wdata,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty,
  output logic        drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_entry_t     mem [DEPTH];
  logic [AW:0]     wr_ptr_reg;
  logic [AW:0]     rd_ptr_reg;
  logic            do_push;
  logic            do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/bk_bin_loader.sv
// BK .bin download consumer: strips the address/length header, relocates payload words into RAM
// through a write queue. Define BK_BIN_HEADER_EN for header parsing; otherwise raw relocation.
module bk_bin_loader
  import bk_loader_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [24:0] RAM_BASE   = RAM_BASE_DEFAULT,
  parameter logic [24:0] DL_BASE    = DL_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [15:0] dl_data,
  output logic        mem_req,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_dout,
  input  logic        mem_ack,
  output logic [15:0] load_addr,
  output logic [15:0] load_len,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

`ifdef BK_BIN_HEADER_EN
  localparam state_t FIRST_STATE = HDR_ADDR;
`else
  localparam state_t FIRST_STATE = DATA;
`endif

  state_t      state_reg;
  state_t      state_next;
  logic        dl_wr_q_reg;
  logic        dl_active_q_reg;
  logic        ev;
  logic        act_rise;
  logic        act_fall;
  logic        push_ok;
  fifo_entry_t push_entry;
  logic        ev_q_reg;
  fifo_entry_t entry_q_reg;
  logic        overflow_reg;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_drop;
  fifo_entry_t fifo_head;

  assign ev       = dl_wr & ~dl_wr_q_reg;
  assign act_rise = dl_active & ~dl_active_q_reg;
  assign act_fall = ~dl_active & dl_active_q_reg;

  // dl_active history starts high so a download already running across reset is not restarted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_wr_q_reg     <= 1'b0;
      dl_active_q_reg <= 1'b1;
    end else begin
      dl_wr_q_reg     <= dl_wr;
      dl_active_q_reg <= dl_active;
    end
  end

`ifdef BK_BIN_HEADER_EN
  logic [23:0] widx;
  logic [15:0] load_addr_reg;
  logic [15:0] load_len_reg;
  logic [16:0] bytes_reg;
  logic [24:0] hdr_addr;

  assign widx     = word_index(dl_addr, DL_BASE);
  assign hdr_addr = RAM_BASE + {9'b0, load_addr_reg} + {widx - 24'd2, 1'b0};

  always_comb begin
    push_ok         = ev && (state_reg == DATA) && (widx >= 24'd2) &&
                      (bytes_reg < {1'b0, load_len_reg});
    push_entry.addr = hdr_addr & ~25'd1;
    push_entry.data = dl_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_addr_reg <= '0;
      load_len_reg  <= '0;
      bytes_reg     <= '0;
    end else if (act_rise) begin
      bytes_reg <= '0;
    end else if (ev) begin
      if (state_reg == HDR_ADDR && widx == 24'd0) load_addr_reg <= dl_data;
      if (state_reg == HDR_LEN  && widx == 24'd1) load_len_reg  <= dl_data;
      if (push_ok) bytes_reg <= bytes_reg + 17'd2;
    end
  end

  assign load_addr = load_addr_reg;
  assign load_len  = load_len_reg;
`else
  logic [24:0] raw_addr;

  assign raw_addr = RAM_BASE + (dl_addr - DL_BASE);

  always_comb begin
    push_ok         = ev && (state_reg == DATA);
    push_entry.addr = raw_addr & ~25'd1;
    push_entry.data = dl_data;
  end

  assign load_addr = '0;
  assign load_len  = '0;
`endif

  // One register stage between strobe detection and the queue keeps the address adder off the FIFO path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev_q_reg    <= 1'b0;
      entry_q_reg <= '0;
    end else begin
      ev_q_reg <= push_ok && !act_rise;
      if (push_ok) entry_q_reg <= push_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          overflow_reg <= 1'b0;
    else if (act_rise)  overflow_reg <= 1'b0;
    else if (fifo_drop) overflow_reg <= 1'b1;
  end

  bk_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (act_rise),
    .push  (ev_q_reg),
    .pop   (mem_ack),
    .wdata (entry_q_reg),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (act_rise) begin
      state_next = FIRST_STATE;
    end else if (act_fall && state_reg != IDLE && state_reg != DRAIN) begin
      state_next = DRAIN;
    end else begin
      case (state_reg)
`ifdef BK_BIN_HEADER_EN
        HDR_ADDR: if (ev && widx == 24'd0) state_next = HDR_LEN;
        HDR_LEN:  if (ev && widx == 24'd1) state_next = DATA;
`endif
        DRAIN:    if (fifo_empty && !ev_q_reg) state_next = IDLE;
        default:  state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    busy = (state_reg != IDLE) || !fifo_empty;
    done = (state_reg == DRAIN) && fifo_empty && !ev_q_reg;
  end

  assign mem_req  = !fifo_empty;
  assign mem_addr = fifo_empty ? 25'd0 : fifo_head.addr;
  assign mem_dout = fifo_empty ? 16'd0 : fifo_head.data;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_bk_bin_loader.sv
// Self-checking bench for bk_bin_loader against a queue-based model of the download format.
// Follows BK_BIN_HEADER_EN the same way the design does.
module tb_bk_bin_loader;

  localparam int          DEPTH    = 4;
  localparam logic [24:0] RAM_BASE = 25'h0000000;
  localparam logic [24:0] DL_BASE  = 25'h00A0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dl_active = 1'b0;
  logic        dl_wr = 1'b0;
  logic [24:0] dl_addr = '0;
  logic [15:0] dl_data = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req;
  logic [24:0] mem_addr;
  logic [15:0] mem_dout;
  logic [15:0] load_addr;
  logic [15:0] load_len;
  logic        busy;
  logic        done;
  logic        overflow;

  bk_bin_loader #(
    .FIFO_DEPTH (DEPTH),
    .RAM_BASE   (RAM_BASE),
    .DL_BASE    (DL_BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_ack   (mem_ack),
    .load_addr (load_addr),
    .load_len  (load_len),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] a;
    logic [15:0] d;
  } wr_t;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];
  wr_t obs_q[$];
  wr_t mon_e;
  int  done_cnt = 0;
  bit  ack_en = 0;
  bit  ack_rand = 0;
  int  ack_wait = 0;

  // Model of the download as the loader should see it.
  bit          m_idle = 1;
  int          m_phase = 0;
  logic [15:0] m_la = '0;
  logic [15:0] m_len = '0;
  int          m_bytes = 0;
  bit          m_ovf = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_push(input logic [24:0] a, input logic [15:0] d);
    if (exp_q.size() >= DEPTH) m_ovf = 1;
    else exp_q.push_back('{a & ~25'd1, d});
  endtask

  task automatic model_event(input logic [24:0] a, input logic [15:0] d);
`ifdef BK_BIN_HEADER_EN
    int w;
    if (m_idle) return;
    w = int'((a - DL_BASE) >> 1);
    if (m_phase == 0) begin
      if (w == 0) begin m_la = d; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (w == 1) begin m_len = d; m_phase = 2; end
    end else if (w >= 2 && m_bytes < int'(m_len)) begin
      model_push(RAM_BASE + 25'(m_la) + 25'(2 * (w - 2)), d);
      m_bytes += 2;
    end
`else
    if (m_idle) return;
    model_push(RAM_BASE + a - DL_BASE, d);
`endif
  endtask

  // Memory-side responder and scoreboard: an ack decided here is accepted on the next rising edge.
  always @(negedge clk) begin
    if (!mem_req || !ack_en) mem_ack = 1'b0;
    else if (ack_rand)       mem_ack = (ack_wait >= 2) || ($urandom_range(0, 1) == 1);
    else                     mem_ack = (ack_wait >= 1);
    if (mem_req && !mem_ack) ack_wait++;
    else                     ack_wait = 0;
    if (mem_req && mem_ack) begin
      obs_q.push_back('{mem_addr, mem_dout});
      $display("wr addr=%h data=%h", mem_addr, mem_dout);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%h:%h required=none", mem_addr, mem_dout);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_e.a));
        check("wr_data", 32'(mem_dout), 32'(mon_e.d));
      end
    end
    if (mem_req) check("busy_with_req", 32'(busy), 32'd1);
    if (done) begin
      done_cnt++;
      check("done_drained", 32'(exp_q.size()), 32'd0);
      check("done_no_req", 32'(mem_req), 32'd0);
    end
  end

  task automatic send_word(input logic [24:0] a, input logic [15:0] d, input int gap);
    @(negedge clk);
    dl_addr = a;
    dl_data = d;
    dl_wr   = 1'b1;
    model_event(a, d);
    @(negedge clk);
    @(negedge clk);
    dl_wr = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Word sent into an empty queue with no ack: request appears on the second edge after detection.
  task automatic send_word_lat(input logic [24:0] a, input logic [15:0] d);
    @(negedge clk);
    dl_addr = a;
    dl_data = d;
    dl_wr   = 1'b1;
    model_event(a, d);
    @(negedge clk);
    check("lat_edge1_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("lat_edge2_req", 32'(mem_req), 32'd1);
    dl_wr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_dl();
    @(negedge clk);
    dl_active = 1'b1;
    m_idle    = 0;
    m_phase   = 0;
    m_bytes   = 0;
    m_ovf     = 0;
    exp_q.delete();
    obs_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic end_dl();
    @(negedge clk);
    dl_active = 1'b0;
    m_idle    = 1;
  endtask

  task automatic wait_done(input string name);
    int start;
    start = done_cnt;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_cnt != start) break;
    end
    repeat (4) @(negedge clk);
    check(name, 32'(done_cnt - start), 32'd1);
  endtask

  task automatic check_obs(input string name, input int i, input logic [24:0] a, input logic [15:0] d);
    logic [24:0] oa;
    logic [15:0] od;
    oa = '1;
    od = '1;
    if (i < obs_q.size()) begin
      oa = obs_q[i].a;
      od = obs_q[i].d;
    end
    check({name, "_addr"}, 32'(oa), 32'(a));
    check({name, "_data"}, 32'(od), 32'(d));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_mem_req"},   32'(mem_req),   32'd0);
    check({name, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({name, "_mem_dout"},  32'(mem_dout),  32'd0);
    check({name, "_load_addr"}, 32'(load_addr), 32'd0);
    check({name, "_load_len"},  32'(load_len),  32'd0);
    check({name, "_busy"},      32'(busy),      32'd0);
    check({name, "_done"},      32'(done),      32'd0);
    check({name, "_overflow"},  32'(overflow),  32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic download
    ack_en = 0;
    ack_rand = 0;
    start_dl();
`ifdef BK_BIN_HEADER_EN
    send_word(DL_BASE, 16'h1000, 2);
    send_word(DL_BASE + 25'd2, 16'h0006, 2);
    send_word_lat(DL_BASE + 25'd4, 16'hA1A2);
    ack_en = 1;
    send_word(DL_BASE + 25'd6, 16'hB1B2, 2);
    send_word(DL_BASE + 25'd8, 16'hC1C2, 2);
    end_dl();
    wait_done("t1_done");
    check("t1_load_addr", 32'(load_addr), 32'h1000);
    check("t1_load_len", 32'(load_len), 32'd6);
    check("t1_count", 32'(obs_q.size()), 32'd3);
    check_obs("t1_w0", 0, 25'h1000, 16'hA1A2);
    check_obs("t1_w1", 1, 25'h1002, 16'hB1B2);
    check_obs("t1_w2", 2, 25'h1004, 16'hC1C2);

    // Length truncation
    start_dl();
    send_word(DL_BASE, 16'h2000, 2);
    send_word(DL_BASE + 25'd2, 16'h0002, 2);
    for (int i = 0; i < 3; i++) send_word(DL_BASE + 25'(4 + 2 * i), 16'h2200 + 16'(i), 2);
    end_dl();
    wait_done("t2_done");
    check("t2_count", 32'(obs_q.size()), 32'd1);
    check_obs("t2_w0", 0, 25'h2000, 16'h2200);
    check("t2_overflow", 32'(overflow), 32'd0);
`else
    send_word_lat(DL_BASE, 16'h1234);
    ack_en = 1;
    send_word(DL_BASE + 25'd2, 16'h5678, 2);
    end_dl();
    wait_done("t1_done");
    check("t1_load_addr", 32'(load_addr), 32'd0);
    check("t1_load_len", 32'(load_len), 32'd0);
    check("t1_count", 32'(obs_q.size()), 32'd2);
    check_obs("t1_w0", 0, 25'h0000000, 16'h1234);
    check_obs("t1_w1", 1, 25'h0000002, 16'h5678);

    // Relocation below the download base wraps modulo 2^25
    start_dl();
    send_word(25'h0000010, 16'hBEEF, 2);
    end_dl();
    wait_done("t2_done");
    check("t2_count", 32'(obs_q.size()), 32'd1);
    check_obs("t2_w0", 0, 25'h1F60010, 16'hBEEF);
`endif

    // Backpressure with overflow
    ack_en = 0;
    start_dl();
    check("t3_ovf_cleared", 32'(overflow), 32'd0);
`ifdef BK_BIN_HEADER_EN
    send_word(DL_BASE, 16'h3000, 2);
    send_word(DL_BASE + 25'd2, 16'd12, 2);
    for (int i = 0; i < 6; i++) send_word(DL_BASE + 25'(4 + 2 * i), 16'h3300 + 16'(i), 2);
`else
    for (int i = 0; i < 6; i++) send_word(DL_BASE + 25'(2 * i), 16'h3300 + 16'(i), 2);
`endif
    repeat (3) @(negedge clk);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_model_ovf", 32'(overflow), 32'(m_ovf));
    check("t3_req", 32'(mem_req), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    ack_en = 1;
    end_dl();
    wait_done("t3_done");
    check("t3_count", 32'(obs_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef BK_BIN_HEADER_EN
      check_obs("t3_w", i, 25'h3000 + 25'(2 * i), 16'h3300 + 16'(i));
`else
      check_obs("t3_w", i, 25'(2 * i), 16'h3300 + 16'(i));
`endif
    end
    check("t3_ovf_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of the payload
    ack_en = 0;
    start_dl();
`ifdef BK_BIN_HEADER_EN
    send_word(DL_BASE, 16'h4000, 2);
    send_word(DL_BASE + 25'd2, 16'd20, 2);
    send_word(DL_BASE + 25'd4, 16'h4401, 2);
    send_word(DL_BASE + 25'd6, 16'h4402, 2);
`else
    send_word(DL_BASE, 16'h4401, 2);
    send_word(DL_BASE + 25'd2, 16'h4402, 2);
`endif
    check("t4_req_before", 32'(mem_req), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("t4_reset");
    @(negedge clk);
    check_all_zero("t4_reset_held");
    reset = 1'b0;
    m_idle = 1;
    exp_q.delete();
    obs_q.delete();
    ack_en = 1;
    for (int i = 0; i < 3; i++) send_word(DL_BASE + 25'(2 * i), 16'h4500 + 16'(i), 2);
    repeat (4) @(negedge clk);
    check("t4_no_req", 32'(mem_req), 32'd0);
    check("t4_no_busy", 32'(busy), 32'd0);
    check("t4_no_writes", 32'(obs_q.size()), 32'd0);
    end_dl();
    repeat (4) @(negedge clk);

    // Randomized downloads with a responder that never stalls more than two cycles
    for (int n = 0; n < 8; n++) begin
      int cnt;
      ack_en = 1;
      ack_rand = 1;
      start_dl();
`ifdef BK_BIN_HEADER_EN
      send_word(DL_BASE, 16'($urandom), $urandom_range(2, 4));
      send_word(DL_BASE + 25'd2, 16'($urandom_range(0, 24)), $urandom_range(2, 4));
      cnt = $urandom_range(0, 14);
      for (int i = 0; i < cnt; i++)
        send_word(DL_BASE + 25'(4 + 2 * i), 16'($urandom), $urandom_range(2, 4));
`else
      cnt = $urandom_range(1, 12);
      for (int i = 0; i < cnt; i++) begin
        logic [24:0] a;
        a = ($urandom_range(0, 1) == 1) ? DL_BASE + 25'(2 * i) : (25'($urandom) & ~25'd1);
        send_word(a, 16'($urandom), $urandom_range(2, 4));
      end
`endif
      end_dl();
      wait_done("rnd_done");
      check("rnd_overflow", 32'(overflow), 32'd0);
`ifdef BK_BIN_HEADER_EN
      check("rnd_load_addr", 32'(load_addr), 32'(m_la));
      check("rnd_load_len", 32'(load_len), 32'(m_len));
`else
      check("rnd_load_addr", 32'(load_addr), 32'd0);
`endif
    end
    check("final_exp_empty", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bk_bin_loader.md
Name: bk_bin_loader

Overview:
- Downstream consumer of the OSD/SPI file download stage. Takes its 16-bit word write strobes (wr, a, d, downloading) and strips the 4-byte BK .bin header (load address word, then length word).
- Relocates payload words to RAM_BASE + load address and queues them in a small FIFO. The FIFO drains to the SDRAM/RAM controller over a req/ack handshake.
- Reports load address, length and completion so the core can auto-start the image.

Parameters:
- FIFO_DEPTH, 4, write-queue depth in words (power of two, >=2).
- RAM_BASE, 25'h000000, byte address in RAM where BK address 0 maps.
- DL_BASE, 25'hA0000, byte address of the first downloaded word as issued by the download stage.

Ports:
- clk  in  1  system clock; same clock as the download stage's clk.
- reset  in  1  asynchronous, active-high reset.
- dl_active  in  1  download in progress (download stage "downloading").
- dl_wr  in  1  word write strobe, 2 clk cycles wide per word.
- dl_addr  in  25  even byte address of the word.
- dl_data  in  16  word data, little-endian: [7:0] is the even byte.
- mem_req  out  1  write request to RAM controller.
- mem_addr  out  25  RAM byte address, bit0 always 0.
- mem_dout  out  16  write data.
- mem_ack  in  1  one-cycle accept of the current request.
- load_addr  out  16  header word 0.
- load_len  out  16  header word 1, in bytes.
- busy  out  1  loader active or FIFO not empty.
- done  out  1  one-cycle pulse when the load is complete and the FIFO is drained.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.

Behaviour:
- Reset values: mem_req=0, mem_addr=0, mem_dout=0, load_addr=0, load_len=0, busy=0, done=0, overflow=0; FIFO empty; state IDLE.
- Strobe detection: a word event is the rising edge of dl_wr (registered previous value). dl_addr/dl_data are sampled on that edge cycle. The 2-cycle strobe therefore yields exactly one event.
- Word index: widx = (dl_addr - DL_BASE) >> 1, 24-bit.
- States:
  - IDLE: on dl_active rising edge -> HDR_ADDR; clear overflow and byte counter.
  - HDR_ADDR: event with widx==0 -> latch load_addr, go to HDR_LEN.
  - HDR_LEN: event with widx==1 -> latch load_len, go to DATA.
  - DATA: each event with widx>=2 and bytes_written < load_len -> push {RAM_BASE + load_addr + 2*(widx-2), dl_data}; bytes_written += 2. Events past load_len are discarded without raising overflow.
  - Address arithmetic: load_addr is zero-extended to 25 bits; the sum wraps mod 2^25.
  - DRAIN: entered from any state on dl_active falling edge. Stays until the FIFO is empty, then pulses done for 1 cycle -> IDLE.
- Early end: dl_active falling in HDR_ADDR or HDR_LEN -> DRAIN with no data. done still pulses; load_len keeps whatever was latched.
- Odd load_len: the final word is written in full (bytes_written reaches load_len+1).
- FIFO:
  - Push and pop in the same cycle are both honoured.
  - Push when full drops the word and sets overflow.
  - The head entry drives mem_addr/mem_dout; mem_req = !empty.
  - A pop happens on mem_ack while mem_req=1. mem_addr/mem_dout change only after an ack.
  - mem_ack while mem_req=0 is ignored.
- Latency: event edge -> mem_req high is 2 cycles when the FIFO is empty.
- busy = (state != IDLE) | !empty.
- Reset mid-download: everything clears immediately, including the FIFO. Later strobes are ignored until the next dl_active rising edge.
- A dl_active rising edge while not IDLE restarts at HDR_ADDR and flushes the FIFO.

Optional Feature:
- BK_BIN_HEADER_EN
  - Defined: header parsing as above.
  - Undefined: raw mode. IDLE goes straight to DATA. Every event is pushed with mem_addr = RAM_BASE + (dl_addr - DL_BASE), and there is no length limit. load_addr and load_len stay 0; done and overflow behave the same.

Decomposition:
- Shared package bk_loader_pkg: state enum (IDLE, HDR_ADDR, HDR_LEN, DATA, DRAIN), the FIFO entry typedef {addr[24:0], data[15:0]}, and defaults for DL_BASE and RAM_BASE.
- One sub-module: bk_wr_fifo, a parameterised synchronous FIFO (push/pop/full/empty, head read) with async active-high reset.

Test Plan:
- Header plus data. Words {0x1000, 0x0006, 0xA1A2, 0xB1B2, 0xC1C2} at dl_addr 0xA0000..0xA0008, mem_ack one cycle after each req.
  - load_addr=0x1000, load_len=6.
  - Writes 0xA1A2@0x1000, 0xB1B2@0x1002, 0xC1C2@0x1004.
  - done pulses once after dl_active falls.
- Length truncation. load_len=2 with 3 data words -> one write at load_addr only; overflow=0.
- Backpressure. mem_ack held low, 6 data words with FIFO_DEPTH=4.
  - 4 queued, overflow=1.
  - After releasing ack, exactly 4 writes in order.
  - done only after the last ack.
- Strobe width. Each dl_wr is high for 2 cycles -> exactly one FIFO push per word; a simultaneous push+pop keeps the count constant.
- Reset mid-DATA. Assert reset after 2 data words with the FIFO non-empty -> mem_req=0 next cycle, all outputs zero, and no write on subsequent strobes until a new dl_active edge.
- Raw mode (macro undefined). Words at 0xA0000 and 0xA0002 with RAM_BASE=0 -> writes @0x0 and @0x2 with the unmodified data.
